// File: rtl/iob_ibex2axi_bridge.sv
// Ibex req/gnt/rvalid to AXI4 master bridge: single-beat accesses, up to
// MAX_OUTSTANDING in flight, responses returned to Ibex in request order.
module iob_ibex2axi_bridge #(
  parameter int AXI_ID_W        = 1,
  parameter int AXI_ID          = 0,
  parameter int AXI_ADDR_W      = 32,
  parameter int AXI_DATA_W      = 32,
  parameter int AXI_LEN_W       = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                    clk_i,
  input  logic                    arst_n_i,
  input  logic                    cke_i,
  input  logic                    ibex_req_i,
  input  logic                    ibex_we_i,
  input  logic [3:0]              ibex_be_i,
  input  logic [31:0]             ibex_addr_i,
  input  logic [31:0]             ibex_wdata_i,
  output logic                    ibex_gnt_o,
  output logic                    ibex_rvalid_o,
  output logic                    ibex_err_o,
  output logic [31:0]             ibex_rdata_o,
  output logic [6:0]              ibex_rdata_intg_o,
  output logic                    awvalid_o,
  input  logic                    awready_i,
  output logic [AXI_ADDR_W-1:0]   awaddr_o,
  output logic [AXI_ID_W-1:0]     awid_o,
  output logic [AXI_LEN_W-1:0]    awlen_o,
  output logic [2:0]              awsize_o,
  output logic [1:0]              awburst_o,
  output logic                    awlock_o,
  output logic [3:0]              awcache_o,
  output logic [2:0]              awprot_o,
  output logic [3:0]              awqos_o,
  output logic                    wvalid_o,
  input  logic                    wready_i,
  output logic [AXI_DATA_W-1:0]   wdata_o,
  output logic [AXI_DATA_W/8-1:0] wstrb_o,
  output logic                    wlast_o,
  input  logic                    bvalid_i,
  output logic                    bready_o,
  input  logic [1:0]              bresp_i,
  input  logic [AXI_ID_W-1:0]     bid_i,
  output logic                    arvalid_o,
  input  logic                    arready_i,
  output logic [AXI_ADDR_W-1:0]   araddr_o,
  output logic [AXI_ID_W-1:0]     arid_o,
  output logic [AXI_LEN_W-1:0]    arlen_o,
  output logic [2:0]              arsize_o,
  output logic [1:0]              arburst_o,
  output logic                    arlock_o,
  output logic [3:0]              arcache_o,
  output logic [2:0]              arprot_o,
  output logic [3:0]              arqos_o,
  input  logic                    rvalid_i,
  output logic                    rready_o,
  input  logic [AXI_DATA_W-1:0]   rdata_i,
  input  logic [1:0]              rresp_i,
  input  logic [AXI_ID_W-1:0]     rid_i,
  input  logic                    rlast_i
);

  localparam int NLANES = AXI_DATA_W / 32;
  localparam int STRB_W = AXI_DATA_W / 8;
  localparam int LANE_W = (NLANES > 1) ? $clog2(NLANES) : 1;
  localparam int PTR_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);

  logic [31:0]         addr_q;
  logic [AXI_DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic                awvalid_q, wvalid_q, arvalid_q;
  logic                fifo_we   [MAX_OUTSTANDING];
  logic [LANE_W-1:0]   fifo_lane [MAX_OUTSTANDING];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    count;
  logic                rsp_valid_q, rsp_err_q;
  logic [31:0]         rsp_rdata_q;

  logic                issue_busy, empty, head_we, pop, pop_err;
  logic [LANE_W-1:0]   req_lane, head_lane;
  logic [31:0]         lane_rdata, pop_rdata;
  logic                unused_inputs;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Lane selection only exists when the AXI bus is wider than one Ibex word.
  generate
    if (NLANES > 1) begin : g_lanes
      assign req_lane   = ibex_addr_i[$clog2(STRB_W)-1:2];
      assign lane_rdata = rdata_i[head_lane*32 +: 32];
    end else begin : g_single_lane
      assign req_lane   = '0;
      assign lane_rdata = rdata_i[31:0];
    end
  endgenerate

  assign issue_busy = awvalid_q | wvalid_q | arvalid_q;
  assign empty      = (count == '0);
  assign head_we    = fifo_we[rd_ptr];
  assign head_lane  = fifo_lane[rd_ptr];

  assign ibex_gnt_o = ibex_req_i & cke_i & ~issue_busy & (count < MAX_CNT);

  // Only the channel matching the oldest request may complete; the other stalls.
  assign bready_o  = cke_i & ~empty & head_we;
  assign rready_o  = cke_i & ~empty & ~head_we;
  assign pop       = (bvalid_i & bready_o) | (rvalid_i & rready_o);
  assign pop_err   = head_we ? bresp_i[1] : rresp_i[1];
  assign pop_rdata = head_we ? 32'h0 : lane_rdata;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        fifo_we[i]   <= 1'b0;
        fifo_lane[i] <= '0;
      end
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else if (cke_i) begin
      if (ibex_gnt_o) begin
        addr_q            <= ibex_addr_i;
        wdata_q           <= {NLANES{ibex_wdata_i}};
        wstrb_q           <= STRB_W'(ibex_be_i) << (4 * req_lane);
        awvalid_q         <= ibex_we_i;
        wvalid_q          <= ibex_we_i;
        arvalid_q         <= ~ibex_we_i;
        fifo_we[wr_ptr]   <= ibex_we_i;
        fifo_lane[wr_ptr] <= req_lane;
        wr_ptr            <= ptr_inc(wr_ptr);
      end else begin
        if (awready_i) awvalid_q <= 1'b0;
        if (wready_i)  wvalid_q  <= 1'b0;
        if (arready_i) arvalid_q <= 1'b0;
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      if (ibex_gnt_o && !pop)      count <= count + 1'b1;
      else if (!ibex_gnt_o && pop) count <= count - 1'b1;
      rsp_valid_q <= pop;
      if (pop) begin
        rsp_err_q   <= pop_err;
        rsp_rdata_q <= pop_rdata;
      end
    end
  end

  assign ibex_rvalid_o     = rsp_valid_q;
  assign ibex_err_o        = rsp_err_q;
  assign ibex_rdata_o      = rsp_rdata_q;
  assign ibex_rdata_intg_o = '0;

  assign awvalid_o = awvalid_q;
  assign awaddr_o  = AXI_ADDR_W'({addr_q[31:2], 2'b00});
  assign awid_o    = AXI_ID_W'(AXI_ID);
  assign awlen_o   = '0;
  assign awsize_o  = 3'd2;
  assign awburst_o = 2'b01;
  assign awlock_o  = 1'b0;
  assign awcache_o = '0;
  assign awprot_o  = '0;
  assign awqos_o   = '0;

  assign wvalid_o  = wvalid_q;
  assign wdata_o   = wdata_q;
  assign wstrb_o   = wstrb_q;
  assign wlast_o   = 1'b1;

  assign arvalid_o = arvalid_q;
  assign araddr_o  = AXI_ADDR_W'({addr_q[31:2], 2'b00});
  assign arid_o    = AXI_ID_W'(AXI_ID);
  assign arlen_o   = '0;
  assign arsize_o  = 3'd2;
  assign arburst_o = 2'b01;
  assign arlock_o  = 1'b0;
  assign arcache_o = '0;
  assign arprot_o  = '0;
  assign arqos_o   = '0;

  assign unused_inputs = ^{addr_q[1:0], bid_i, rid_i, rlast_i, bresp_i[0], rresp_i[0]};

endmodule

// File: tb/tb_iob_ibex2axi_bridge.sv
// Scoreboard bench for iob_ibex2axi_bridge on a 64-bit AXI bus with two
// outstanding slots; directed slave behaviour per scenario.
module tb_iob_ibex2axi_bridge;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  logic        clk;
  logic        arst_n;
  logic        cke;
  logic        req, we;
  logic [3:0]  be;
  logic [31:0] addr, wdata;
  logic        gnt, ibex_rvalid, ibex_err;
  logic [31:0] ibex_rdata;
  logic [6:0]  ibex_intg;
  logic        awvalid, awready, awlock, wvalid, wready, wlast;
  logic [31:0] awaddr, araddr;
  logic [0:0]  awid, arid, bid, rid;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize, awprot, arprot;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic [3:0]  awcache, arcache, awqos, arqos;
  logic [63:0] wdata_axi, rdata_axi;
  logic [7:0]  wstrb;
  logic        bvalid, bready, arvalid, arready, arlock, rvalid, rready, rlast;

  rsp_t        exp_rsp[$];
  logic [31:0] exp_aw[$];
  logic [31:0] exp_ar[$];
  logic [71:0] exp_w[$];

  int tests_run = 0;
  int failed = 0;
  int aw_cnt, w_cnt;

  iob_ibex2axi_bridge #(
    .AXI_ID_W(1), .AXI_ID(0), .AXI_ADDR_W(32), .AXI_DATA_W(64),
    .AXI_LEN_W(8), .MAX_OUTSTANDING(2)
  ) dut (
    .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke),
    .ibex_req_i(req), .ibex_we_i(we), .ibex_be_i(be), .ibex_addr_i(addr),
    .ibex_wdata_i(wdata), .ibex_gnt_o(gnt), .ibex_rvalid_o(ibex_rvalid),
    .ibex_err_o(ibex_err), .ibex_rdata_o(ibex_rdata), .ibex_rdata_intg_o(ibex_intg),
    .awvalid_o(awvalid), .awready_i(awready), .awaddr_o(awaddr), .awid_o(awid),
    .awlen_o(awlen), .awsize_o(awsize), .awburst_o(awburst), .awlock_o(awlock),
    .awcache_o(awcache), .awprot_o(awprot), .awqos_o(awqos),
    .wvalid_o(wvalid), .wready_i(wready), .wdata_o(wdata_axi), .wstrb_o(wstrb),
    .wlast_o(wlast),
    .bvalid_i(bvalid), .bready_o(bready), .bresp_i(bresp), .bid_i(bid),
    .arvalid_o(arvalid), .arready_i(arready), .araddr_o(araddr), .arid_o(arid),
    .arlen_o(arlen), .arsize_o(arsize), .arburst_o(arburst), .arlock_o(arlock),
    .arcache_o(arcache), .arprot_o(arprot), .arqos_o(arqos),
    .rvalid_i(rvalid), .rready_o(rready), .rdata_i(rdata_axi), .rresp_i(rresp),
    .rid_i(rid), .rlast_i(rlast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic expectResponse(input logic err, input logic [31:0] rdata);
    rsp_t r;
    r.err   = err;
    r.rdata = rdata;
    exp_rsp.push_back(r);
  endtask

  // Request until granted, queueing the AXI beat the bridge should issue.
  task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [3:0] b,
                               input logic [31:0] d, input logic [7:0] exp_strb);
    int n = 0;
    req = 1'b1; we = w; addr = a; be = b; wdata = d;
    if (w) begin
      exp_aw.push_back(a & 32'hFFFF_FFFC);
      exp_w.push_back({d, d, exp_strb});
    end else begin
      exp_ar.push_back(a & 32'hFFFF_FFFC);
    end
    @(negedge clk);
    while (!gnt && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!gnt) checkOutput("gnt_timeout", 0, 1);
    tick;
    req = 1'b0;
  endtask

  task automatic waitB(input logic [1:0] resp);
    int n = 0;
    while ((awvalid || wvalid) && n < 20) begin tick; n++; end
    bvalid = 1'b1; bresp = resp; n = 0;
    @(negedge clk);
    while (!bready && n < 20) begin @(negedge clk); n++; end
    if (!bready) checkOutput("bready_timeout", 0, 1);
    tick;
    bvalid = 1'b0;
  endtask

  task automatic waitR(input logic [63:0] data, input logic [1:0] resp);
    int n = 0;
    while (arvalid && n < 20) begin tick; n++; end
    rvalid = 1'b1; rdata_axi = data; rresp = resp; n = 0;
    @(negedge clk);
    while (!rready && n < 20) begin @(negedge clk); n++; end
    if (!rready) checkOutput("rready_timeout", 0, 1);
    tick;
    rvalid = 1'b0;
  endtask

  // Monitor: compares every Ibex response and AXI request handshake with the queues.
  always @(negedge clk) begin : monitor
    rsp_t r;
    if (arst_n) begin
      if (ibex_rvalid) begin
        if (exp_rsp.size() == 0) checkOutput("unexpected_rvalid", 1, 0);
        else begin
          r = exp_rsp.pop_front();
          checkOutput("rsp_err", ibex_err, r.err);
          checkOutput("rsp_rdata", ibex_rdata, r.rdata);
        end
      end
      if (awvalid && awready) begin
        if (exp_aw.size() == 0) checkOutput("unexpected_aw", 1, 0);
        else checkOutput("aw_addr", awaddr, exp_aw.pop_front());
      end
      if (wvalid && wready) begin
        if (exp_w.size() == 0) checkOutput("unexpected_w", 1, 0);
        else checkOutput("w_data_strb", {wdata_axi, wstrb}, exp_w.pop_front());
      end
      if (arvalid && arready) begin
        if (exp_ar.size() == 0) checkOutput("unexpected_ar", 1, 0);
        else checkOutput("ar_addr", araddr, exp_ar.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got 0x0, expected 0x1");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    arst_n = 1'b0; cke = 1'b1; req = 1'b0; we = 1'b0; be = 4'h0; addr = '0; wdata = '0;
    awready = 1'b1; wready = 1'b1; arready = 1'b1;
    bvalid = 1'b0; bresp = 2'b00; bid = '0;
    rvalid = 1'b0; rdata_axi = '0; rresp = 2'b00; rid = '0; rlast = 1'b1;

    #12;
    checkOutput("rst_valids", {awvalid, wvalid, arvalid}, 3'b000);
    checkOutput("rst_readys", {bready, rready}, 2'b00);
    checkOutput("rst_ibex_rsp", {ibex_rvalid, ibex_err, ibex_rdata}, 34'h0);
    @(posedge clk);
    #3 arst_n = 1'b1;
    tick;

    // Single write, zero-wait slave: gnt c0, AW/W c1, B c2, rvalid c3
    req = 1'b1; we = 1'b1; addr = 32'h104; be = 4'hF; wdata = 32'hDEADBEEF;
    exp_aw.push_back(32'h104);
    exp_w.push_back({64'hDEADBEEF_DEADBEEF, 8'hF0});
    expectResponse(1'b0, 32'h0);
    @(negedge clk);
    checkOutput("s1_gnt", gnt, 1);
    tick;
    req = 1'b0;
    @(negedge clk);
    checkOutput("s1_aw_w_valid", {awvalid, wvalid}, 2'b11);
    checkOutput("s1_fixed", {awid, awlen, awsize, awburst, wlast, awlock, awcache, awprot, awqos},
                {1'b0, 8'd0, 3'd2, 2'b01, 1'b1, 1'b0, 4'd0, 3'd0, 4'd0});
    checkOutput("s1_bready", bready, 1);
    tick;
    bvalid = 1'b1; bresp = 2'b00;
    @(negedge clk);
    checkOutput("s1_aw_done", awvalid, 0);
    tick;
    bvalid = 1'b0;
    @(negedge clk);
    checkOutput("s1_rvalid_cycle3", ibex_rvalid, 1);
    tick;

    // Lane steering on the 64-bit bus
    expectResponse(1'b0, 32'h11223344);
    applyStimulus(1'b0, 32'h1004, 4'h0, 32'h0, 8'h00);
    checkOutput("s2_arfixed", {arid, arlen, arsize, arburst}, {1'b0, 8'd0, 3'd2, 2'b01});
    waitR(64'h11223344_55667788, 2'b00);
    expectResponse(1'b0, 32'h01020304);
    applyStimulus(1'b0, 32'h1000, 4'h0, 32'h0, 8'h00);
    waitR(64'hAABBCCDD_01020304, 2'b00);
    expectResponse(1'b0, 32'h0);
    applyStimulus(1'b1, 32'h1004, 4'h3, 32'h0000CAFE, 8'h30);
    waitB(2'b00);
    repeat (2) tick;

    // R arrives before B: read must wait behind the older write
    expectResponse(1'b0, 32'h0);
    applyStimulus(1'b1, 32'h200, 4'hF, 32'h12345678, 8'h0F);
    expectResponse(1'b0, 32'h77776666);
    applyStimulus(1'b0, 32'h208, 4'h0, 32'h0, 8'h00);
    rvalid = 1'b1; rdata_axi = 64'h99998888_77776666; rresp = 2'b00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("s3_rready_blocked", rready, 0);
      tick;
    end
    waitB(2'b00);
    waitR(64'h99998888_77776666, 2'b00);
    repeat (2) tick;

    // Full with two outstanding reads; a pop re-enables grant one cycle later
    expectResponse(1'b0, 32'h00000300);
    applyStimulus(1'b0, 32'h300, 4'h0, 32'h0, 8'h00);
    expectResponse(1'b0, 32'h00000304);
    applyStimulus(1'b0, 32'h304, 4'h0, 32'h0, 8'h00);
    tick;
    req = 1'b1; we = 1'b0; addr = 32'h308;
    @(negedge clk);
    checkOutput("s4_full_gnt", gnt, 0);
    tick;
    @(negedge clk);
    checkOutput("s4_full_gnt2", gnt, 0);
    tick;
    rvalid = 1'b1; rdata_axi = 64'hA0A0A0A0_00000300; rresp = 2'b00;
    @(negedge clk);
    checkOutput("s4_pop_rready", rready, 1);
    checkOutput("s4_pop_gnt", gnt, 0);
    tick;
    rvalid = 1'b0;
    exp_ar.push_back(32'h308);
    expectResponse(1'b1, 32'h00000308);
    @(negedge clk);
    checkOutput("s4_regrant", gnt, 1);
    tick;
    req = 1'b0;
    waitR(64'h00000304_B1B1B1B1, 2'b00);
    waitR(64'hC2C2C2C2_00000308, 2'b11);
    repeat (2) tick;

    // AW accepted 3 cycles late, W at once, SLVERR; cke low stalls B
    awready = 1'b0;
    expectResponse(1'b1, 32'h0);
    applyStimulus(1'b1, 32'h400, 4'hF, 32'h0BADF00D, 8'h0F);
    aw_cnt = 0; w_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) awready = 1'b1;
      if (i == 1) begin req = 1'b1; we = 1'b0; addr = 32'h500; end
      if (i == 2) req = 1'b0;
      @(negedge clk);
      if (awvalid) aw_cnt++;
      if (wvalid) w_cnt++;
      if (i == 1) checkOutput("s5_busy_gnt", gnt, 0);
      tick;
    end
    checkOutput("s5_aw_cycles", aw_cnt, 4);
    checkOutput("s5_w_cycles", w_cnt, 1);
    cke = 1'b0; bvalid = 1'b1; bresp = 2'b10; req = 1'b1; we = 1'b0; addr = 32'h500;
    @(negedge clk);
    checkOutput("s5_cke_bready", bready, 0);
    checkOutput("s5_cke_gnt", gnt, 0);
    tick;
    cke = 1'b1; req = 1'b0;
    waitB(2'b10);
    repeat (2) tick;

    // Reset with two reads in flight, one still presenting AR
    applyStimulus(1'b0, 32'h500, 4'h0, 32'h0, 8'h00);
    tick;
    arready = 1'b0;
    applyStimulus(1'b0, 32'h504, 4'h0, 32'h0, 8'h00);
    checkOutput("s7_ar_pending", arvalid, 1);
    #2 arst_n = 1'b0;
    #1;
    checkOutput("s7_valids", {awvalid, wvalid, arvalid}, 3'b000);
    checkOutput("s7_readys", {bready, rready}, 2'b00);
    exp_ar.delete();
    #2 arst_n = 1'b1;
    arready = 1'b1;
    tick;
    req = 1'b1; we = 1'b0; addr = 32'h600;
    exp_ar.push_back(32'h600);
    expectResponse(1'b0, 32'h00ABCDEF);
    @(negedge clk);
    checkOutput("s7_regrant", gnt, 1);
    tick;
    req = 1'b0;
    waitR(64'h12121212_00ABCDEF, 2'b00);
    repeat (3) tick;

    checkOutput("rsp_queue_empty", exp_rsp.size(), 0);
    checkOutput("aw_queue_empty", exp_aw.size(), 0);
    checkOutput("w_queue_empty", exp_w.size(), 0);
    checkOutput("ar_queue_empty", exp_ar.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
